// File: rtl/anpc_level_scheduler_if.sv
// Bus between the modulator-side controller and the ANPC level scheduler.
// The master drives requests and dead-time configuration; the slave returns the FSM-facing outputs.
interface anpc_level_scheduler_if #(
  parameter int W = 10
);
  logic [1:0]   lev_req;
  logic         mode;
  logic [1:0]   cfg_type;
  logic [W-1:0] t_dwell;
  logic [W-1:0] cfg_t_short;
  logic [W-1:0] cfg_t_off_on;
  logic [W-1:0] cfg_t_on_offV0;
  logic [W-1:0] cfg_t_offV0_on;
  logic [W-1:0] cfg_t_off_onI0;
  logic         cfg_load;
  logic         fault_clr;

  logic [1:0]   v_lev;
  logic [1:0]   comm_type;
  logic [W-1:0] t_short;
  logic [W-1:0] t_off_on;
  logic [W-1:0] t_on_offV0;
  logic [W-1:0] t_offV0_on;
  logic [W-1:0] t_off_onI0;
  logic         busy;
  logic         hop;
  logic         cfg_pending;
  logic         fault;

  modport master (
    output lev_req, mode, cfg_type, t_dwell,
           cfg_t_short, cfg_t_off_on, cfg_t_on_offV0, cfg_t_offV0_on, cfg_t_off_onI0,
           cfg_load, fault_clr,
    input  v_lev, comm_type, t_short, t_off_on, t_on_offV0, t_offV0_on, t_off_onI0,
           busy, hop, cfg_pending, fault
  );

  modport slave (
    input  lev_req, mode, cfg_type, t_dwell,
           cfg_t_short, cfg_t_off_on, cfg_t_on_offV0, cfg_t_offV0_on, cfg_t_off_onI0,
           cfg_load, fault_clr,
    output v_lev, comm_type, t_short, t_off_on, t_on_offV0, t_offV0_on, t_off_onI0,
           busy, hop, cfg_pending, fault
  );
endinterface

// File: rtl/anpc_level_scheduler.sv
// Level sequencer ahead of the 3L-ANPC commutation FSM: dwell enforcement, P<->N zero hops,
// commutation-type selection/rotation and shadowed dead-time updates applied only while idle.
module anpc_level_scheduler #(
  parameter int W         = 10,
  parameter int T_DEFAULT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  anpc_level_scheduler_if.slave bus
);
  localparam logic [0:0]   S_IDLE  = 1'b0;
  localparam logic [0:0]   S_DWELL = 1'b1;
  localparam logic [W-1:0] T_DEF   = W'(T_DEFAULT);

  logic [0:0]        state_q, state_d;
  logic [W-1:0]      cnt_q, cnt_d;
  logic [1:0]        lev_q, lev_d;
  logic [1:0]        type_q, type_d;
  logic [1:0]        rot_q, rot_d;
  logic              hop_q, hop_d;
  logic              pending_q, pending_d;
  logic              fault_q, fault_d;
  logic [4:0][W-1:0] dt_q, dt_d;
  logic [4:0][W-1:0] shadow_q, shadow_d;

  logic [W-1:0] dwell_len;
  logic         terminal;
  logic         evaluate;
  logic         change;
  logic         fault_set;

  always_comb begin
    dwell_len = (bus.t_dwell == '0) ? W'(1) : bus.t_dwell;
    terminal  = (state_q == S_DWELL) && (cnt_q == dwell_len - W'(1));
    evaluate  = (state_q == S_IDLE) || terminal;

    state_d   = state_q;
    cnt_d     = cnt_q;
    lev_d     = lev_q;
    type_d    = type_q;
    rot_d     = rot_q;
    hop_d     = hop_q;
    pending_d = pending_q;
    dt_d      = dt_q;
    shadow_d  = shadow_q;
    change    = 1'b0;
    fault_set = 1'b0;

    // No latched hop target: after a zero hop the live request is simply re-evaluated.
    if (evaluate) begin
      if (bus.lev_req == 2'b11) begin
        fault_set = 1'b1;
      end else if (bus.lev_req == lev_q) begin
        hop_d = 1'b0;
      end else begin
        change = 1'b1;
        if ({lev_q, bus.lev_req} == 4'b0110 || {lev_q, bus.lev_req} == 4'b1001) begin
          lev_d = 2'b00;
          hop_d = 1'b1;
        end else begin
          lev_d = bus.lev_req;
          hop_d = 1'b0;
        end
      end
    end

    if (change) begin
      state_d = S_DWELL;
      cnt_d   = '0;
      if (bus.mode) begin
        type_d = rot_q;
        rot_d  = (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
      end else begin
        type_d = (bus.cfg_type == 2'd3) ? 2'd0 : bus.cfg_type;
      end
    end else if (state_q == S_DWELL) begin
      if (terminal) state_d = S_IDLE;
      else          cnt_d   = cnt_q + W'(1);
    end

    // A load coinciding with an apply pushes the old shadow out and keeps the new one pending.
    if (state_q == S_IDLE && !change) begin
      dt_d      = shadow_q;
      pending_d = 1'b0;
    end
    if (bus.cfg_load) begin
      shadow_d  = {bus.cfg_t_off_onI0, bus.cfg_t_offV0_on, bus.cfg_t_on_offV0,
                   bus.cfg_t_off_on, bus.cfg_t_short};
      pending_d = 1'b1;
    end

    fault_d = fault_set ? 1'b1 : (bus.fault_clr ? 1'b0 : fault_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_DWELL;
      cnt_q     <= '0;
      lev_q     <= 2'b00;
      type_q    <= 2'd0;
      rot_q     <= 2'd0;
      hop_q     <= 1'b0;
      pending_q <= 1'b0;
      fault_q   <= 1'b0;
      dt_q      <= {5{T_DEF}};
      shadow_q  <= {5{T_DEF}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lev_q     <= lev_d;
      type_q    <= type_d;
      rot_q     <= rot_d;
      hop_q     <= hop_d;
      pending_q <= pending_d;
      fault_q   <= fault_d;
      dt_q      <= dt_d;
      shadow_q  <= shadow_d;
    end
  end

  assign bus.v_lev       = lev_q;
  assign bus.comm_type   = type_q;
  assign bus.hop         = hop_q;
  assign bus.busy        = (state_q == S_DWELL);
  assign bus.cfg_pending = pending_q;
  assign bus.fault       = fault_q;
  assign bus.t_short     = dt_q[0];
  assign bus.t_off_on    = dt_q[1];
  assign bus.t_on_offV0  = dt_q[2];
  assign bus.t_offV0_on  = dt_q[3];
  assign bus.t_off_onI0  = dt_q[4];
endmodule
